id_ex_register: RTL and testbench
=================================

ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter DATA_W, default 32, width of PC4/operand/immediate datapath fields.
REQ-002 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 Flush  input  1  kill the instruction in decode; next E-stage slot becomes a bubble.
REQ-006 Valid_D  input  1  decode-stage instruction is real (0 = bubble from upstream).
REQ-007 PC4_D, RsData_D, RtData_D, Imm_D  input  DATA_W each  decode-stage datapath values.
REQ-008 RsAddr_D, RtAddr_D, RdAddr_D  input  5 each  decode-stage register addresses.
REQ-009 Ctrl_D  input  CTRL_W  control bundle {RegWriteEN, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, Branch, ALUOp[3:0]}.
REQ-010 PC4_E, RsData_E, RtData_E, Imm_E  output  DATA_W each  registered datapath values.
REQ-011 RsAddr_E, RtAddr_E  output  5 each  registered source addresses, consumed by the forwarding unit.
REQ-012 RegDstAddr_E  output  5  registered destination address; RegWriteEN_E  output  1; Ctrl_E  output  CTRL_W.
REQ-013 Valid_E  output  1  execute-stage slot holds a real instruction.
REQ-014 Stall_D  output  1  combinational load-use stall request to PC and IF/ID registers.
REQ-015 StallCnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-016 Latency: decode values appear on *_E outputs one rising edge after capture.
REQ-017 Stall_D SHALL be 1 iff ~Flush & Valid_E & Ctrl_E.MemRead & RegDstAddr_E!=0 & (RegDstAddr_E==RsAddr_D | RegDstAddr_E==RtAddr_D).
REQ-018 Destination select at capture: RegDstAddr = RegDst ? RdAddr_D : RtAddr_D; forced to 0 when RegWriteEN=0.
REQ-019 Per edge priority: Flush, then Stall_D, then Valid_D=0 each load a bubble; otherwise a normal capture of all D inputs.
REQ-020 Bubble: Valid_E=0, Ctrl_E=0, RegWriteEN_E=0, RegDstAddr_E=0, RsAddr_E=0, RtAddr_E=0; PC4_E/RsData_E/RtData_E/Imm_E hold previous values.
REQ-021 Flush and load-use condition in the same cycle: flush wins; Stall_D=0; a bubble is inserted and StallCnt does not increment.
REQ-022 Load-use stall lasts exactly one cycle: the bubble clears MemRead_E, so Stall_D drops the following cycle with unchanged D inputs.
REQ-023 StallCnt increments by 1 on each edge where Stall_D=1; at 2^CNT_W-1 it holds (no wrap).
REQ-024 Address 0 destination never triggers a stall, even with MemRead set.

Reset
REQ-025 RSTn low asynchronously clears every register: all *_E outputs 0, Valid_E 0, StallCnt 0; Stall_D therefore 0.
REQ-026 Reset release takes effect on the first rising CLK edge with RSTn high; reset mid-stall discards the stalled state with no residual bubble.

Structure
REQ-027 A shared package pipe_pkg SHALL hold CTRL_W (11), the control-bundle field positions, and ALUOp encodings.
REQ-028 The load-use comparator SHALL be a combinational sub-module hazard_detect; all state lives in id_ex_register.

Verification
REQ-029 Reset: RSTn=0 mid-run -> all outputs 0 immediately, without waiting for CLK; StallCnt=0.
REQ-030 Normal capture: add $3,$1,$2 (RegDst=1, Rd=3) -> next edge RsAddr_E=1, RtAddr_E=2, RegDstAddr_E=3, Valid_E=1.
REQ-031 Load-use: lw $5,0($1) in E, decode add $6,$5,$2 -> Stall_D=1 one cycle, bubble in E, StallCnt=1, add captured on following edge.
REQ-032 Flush with load-use condition present -> Stall_D=0, bubble in E, StallCnt unchanged.
REQ-033 lw $0 in E and decode reads $0 -> Stall_D=0.
REQ-034 StallCnt preloaded at 0xFFFE by forcing 2 stalls -> 0xFFFF, further stalls hold 0xFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle layout and ALU operation codes.
package pipe_pkg;

    localparam int unsigned CTRL_W = 11;
    localparam int unsigned REG_AW = 5;

    // Bit positions of the control bundle fields, MSB first.
    localparam int unsigned CTRL_REGWRITE_BIT = 10;
    localparam int unsigned CTRL_MEMREAD_BIT  = 9;
    localparam int unsigned CTRL_MEMWRITE_BIT = 8;
    localparam int unsigned CTRL_MEMTOREG_BIT = 7;
    localparam int unsigned CTRL_ALUSRC_BIT   = 6;
    localparam int unsigned CTRL_REGDST_BIT   = 5;
    localparam int unsigned CTRL_BRANCH_BIT   = 4;
    localparam int unsigned CTRL_ALUOP_LSB    = 0;
    localparam int unsigned CTRL_ALUOP_W      = 4;

    typedef enum logic [CTRL_ALUOP_W-1:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_NOR = 4'h5,
        ALU_SLT = 4'h6,
        ALU_SLL = 4'h7,
        ALU_SRL = 4'h8,
        ALU_SRA = 4'h9,
        ALU_LUI = 4'hA
    } alu_op_e;

    typedef struct packed {
        logic                    reg_write_en;
        logic                    mem_read;
        logic                    mem_write;
        logic                    mem_to_reg;
        logic                    alu_src;
        logic                    reg_dst;
        logic                    branch;
        logic [CTRL_ALUOP_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/id_ex_register_if.sv
// Decode-to-execute bus: decode-side inputs, execute-side outputs, stall feedback.
interface id_ex_register_if
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              Flush;
    logic              Valid_D;
    logic [DATA_W-1:0] PC4_D;
    logic [DATA_W-1:0] RsData_D;
    logic [DATA_W-1:0] RtData_D;
    logic [DATA_W-1:0] Imm_D;
    logic [REG_AW-1:0] RsAddr_D;
    logic [REG_AW-1:0] RtAddr_D;
    logic [REG_AW-1:0] RdAddr_D;
    logic [CTRL_W-1:0] Ctrl_D;

    logic [DATA_W-1:0] PC4_E;
    logic [DATA_W-1:0] RsData_E;
    logic [DATA_W-1:0] RtData_E;
    logic [DATA_W-1:0] Imm_E;
    logic [REG_AW-1:0] RsAddr_E;
    logic [REG_AW-1:0] RtAddr_E;
    logic [REG_AW-1:0] RegDstAddr_E;
    logic              RegWriteEN_E;
    logic [CTRL_W-1:0] Ctrl_E;
    logic              Valid_E;
    logic              Stall_D;
    logic [CNT_W-1:0]  StallCnt;

    modport master (
        output Flush, Valid_D, PC4_D, RsData_D, RtData_D, Imm_D,
               RsAddr_D, RtAddr_D, RdAddr_D, Ctrl_D,
        input  PC4_E, RsData_E, RtData_E, Imm_E, RsAddr_E, RtAddr_E,
               RegDstAddr_E, RegWriteEN_E, Ctrl_E, Valid_E, Stall_D, StallCnt
    );

    modport slave (
        input  Flush, Valid_D, PC4_D, RsData_D, RtData_D, Imm_D,
               RsAddr_D, RtAddr_D, RdAddr_D, Ctrl_D,
        output PC4_E, RsData_E, RtData_E, Imm_E, RsAddr_E, RtAddr_E,
               RegDstAddr_E, RegWriteEN_E, Ctrl_E, Valid_E, Stall_D, StallCnt
    );

endinterface

// File: rtl/id_ex_register_hazard_detect.sv
// Load-use hazard comparator: a load in E whose destination is read in D.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic              flush,
    input  logic              valid_e,
    input  logic              mem_read_e,
    input  logic [REG_AW-1:0] dst_e,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    output logic              stall_c
);

    // Flush suppresses the stall; $0 is never a real dependency.
    always_comb begin
        stall_c = ~flush & valid_e & mem_read_e & (dst_e != REG_AW'(0))
                & ((dst_e == rs_d) | (dst_e == rt_d));
    end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use stall generation and stall counter.
module id_ex_register
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic            CLK,
    input  logic            RSTn,
    id_ex_register_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] rsd_q, rsd_d;
    logic [DATA_W-1:0] rtd_q, rtd_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    ctrl_t ctrl_in;
    logic  stall_c;

    assign ctrl_in = ctrl_t'(bus.Ctrl_D);

    hazard_detect u_hazard (
        .flush      (bus.Flush),
        .valid_e    (valid_q),
        .mem_read_e (ctrl_q.mem_read),
        .dst_e      (dst_q),
        .rs_d       (bus.RsAddr_D),
        .rt_d       (bus.RtAddr_D),
        .stall_c    (stall_c)
    );

    // Next E-stage slot: bubble on flush, stall or upstream bubble, else capture.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        dst_d   = dst_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        pc4_d   = pc4_q;
        rsd_d   = rsd_q;
        rtd_d   = rtd_q;
        imm_d   = imm_q;
        cnt_d   = cnt_q;

        if (bus.Flush || stall_c || !bus.Valid_D) begin
            // Datapath fields hold; only the control/address side is cleared.
            valid_d = 1'b0;
            ctrl_d  = '0;
            dst_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
        end else begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_in;
            rs_d    = bus.RsAddr_D;
            rt_d    = bus.RtAddr_D;
            pc4_d   = bus.PC4_D;
            rsd_d   = bus.RsData_D;
            rtd_d   = bus.RtData_D;
            imm_d   = bus.Imm_D;
            if (!ctrl_in.reg_write_en) begin
                dst_d = '0;
            end else if (ctrl_in.reg_dst) begin
                dst_d = bus.RdAddr_D;
            end else begin
                dst_d = bus.RtAddr_D;
            end
        end

        if (stall_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline state and stall counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            dst_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            pc4_q   <= '0;
            rsd_q   <= '0;
            rtd_q   <= '0;
            imm_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            dst_q   <= dst_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            pc4_q   <= pc4_d;
            rsd_q   <= rsd_d;
            rtd_q   <= rtd_d;
            imm_q   <= imm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Valid_E      = valid_q;
    assign bus.Ctrl_E       = ctrl_q;
    assign bus.RegWriteEN_E = ctrl_q.reg_write_en;
    assign bus.RegDstAddr_E = dst_q;
    assign bus.RsAddr_E     = rs_q;
    assign bus.RtAddr_E     = rt_q;
    assign bus.PC4_E        = pc4_q;
    assign bus.RsData_E     = rsd_q;
    assign bus.RtData_E     = rtd_q;
    assign bus.Imm_E        = imm_q;
    assign bus.StallCnt     = cnt_q;
    assign bus.Stall_D      = stall_c;

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: directed hazards, random traffic, reset, saturation.
module tb_id_ex_register;
    import pipe_pkg::*;

    localparam int unsigned SAT_W   = 3;
    localparam int unsigned MAX16   = 65535;
    localparam int unsigned MAX_SAT = 7;

    localparam logic [10:0] C_ADD = 11'b100_0010_0000; // RegWriteEN, RegDst, ALU_ADD
    localparam logic [10:0] C_LW  = 11'b110_1100_0000; // RegWriteEN, MemRead, MemToReg, ALUSrc

    logic clk;
    logic rst_n;

    id_ex_register_if #(.DATA_W(32), .CNT_W(16))    ifc ();
    id_ex_register_if #(.DATA_W(32), .CNT_W(SAT_W)) ifs ();

    id_ex_register #(.DATA_W(32), .CNT_W(16))    dut   (.CLK(clk), .RSTn(rst_n), .bus(ifc));
    id_ex_register #(.DATA_W(32), .CNT_W(SAT_W)) dut_s (.CLK(clk), .RSTn(rst_n), .bus(ifs));

    assign ifs.Flush    = ifc.Flush;
    assign ifs.Valid_D  = ifc.Valid_D;
    assign ifs.PC4_D    = ifc.PC4_D;
    assign ifs.RsData_D = ifc.RsData_D;
    assign ifs.RtData_D = ifc.RtData_D;
    assign ifs.Imm_D    = ifc.Imm_D;
    assign ifs.RsAddr_D = ifc.RsAddr_D;
    assign ifs.RtAddr_D = ifc.RtAddr_D;
    assign ifs.RdAddr_D = ifc.RdAddr_D;
    assign ifs.Ctrl_D   = ifc.Ctrl_D;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [10:0] ctrl;
        logic [4:0]  dst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] pc4;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
    } e_t;

    typedef struct {
        logic        stall;
        e_t          e;
        int unsigned cnt;
        int unsigned cnt_s;
    } exp_t;

    e_t          m;
    int unsigned stalls;
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m      = '{valid: 1'b0, ctrl: '0, dst: '0, rs: '0, rt: '0,
                   pc4: '0, rsd: '0, rtd: '0, imm: '0};
        stalls = 0;
    endtask

    // Drive one decode slot and record what the E stage must show after the edge.
    task automatic drive(input logic fl, input logic vd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [10:0] ctrl, input logic [31:0] pc4,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm);
        exp_t x;
        logic st;
        @(negedge clk);
        ifc.Flush    = fl;
        ifc.Valid_D  = vd;
        ifc.RsAddr_D = rs;
        ifc.RtAddr_D = rt;
        ifc.RdAddr_D = rd;
        ifc.Ctrl_D   = ctrl;
        ifc.PC4_D    = pc4;
        ifc.RsData_D = rsd;
        ifc.RtData_D = rtd;
        ifc.Imm_D    = imm;
        // A load in E is a hazard if its real (nonzero) destination is read now.
        st = !fl && m.valid && m.ctrl[CTRL_MEMREAD_BIT] && (m.dst != 5'd0)
             && ((m.dst == rs) || (m.dst == rt));
        if (fl || st || !vd) begin
            m.valid = 1'b0;
            m.ctrl  = '0;
            m.dst   = '0;
            m.rs    = '0;
            m.rt    = '0;
        end else begin
            m.valid = 1'b1;
            m.ctrl  = ctrl;
            m.rs    = rs;
            m.rt    = rt;
            m.pc4   = pc4;
            m.rsd   = rsd;
            m.rtd   = rtd;
            m.imm   = imm;
            m.dst   = !ctrl[CTRL_REGWRITE_BIT] ? 5'd0 : (ctrl[CTRL_REGDST_BIT] ? rd : rt);
        end
        if (st) stalls++;
        x.stall = st;
        x.e     = m;
        x.cnt   = (stalls > MAX16)   ? MAX16   : stalls;
        x.cnt_s = (stalls > MAX_SAT) ? MAX_SAT : stalls;
        exp_q.push_back(x);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: check stall before each edge, registered outputs just after it.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                r = exp_q[0];
                chk("stall_d", ifc.Stall_D, r.stall);
                @(posedge clk);
                #1;
                r = exp_q.pop_front();
                chk("valid_e",  ifc.Valid_E,      r.e.valid);
                chk("ctrl_e",   ifc.Ctrl_E,       r.e.ctrl);
                chk("regwr_e",  ifc.RegWriteEN_E, r.e.ctrl[CTRL_REGWRITE_BIT]);
                chk("dst_e",    ifc.RegDstAddr_E, r.e.dst);
                chk("rs_e",     ifc.RsAddr_E,     r.e.rs);
                chk("rt_e",     ifc.RtAddr_E,     r.e.rt);
                chk("pc4_e",    ifc.PC4_E,        r.e.pc4);
                chk("rsdata_e", ifc.RsData_E,     r.e.rsd);
                chk("rtdata_e", ifc.RtData_E,     r.e.rtd);
                chk("imm_e",    ifc.Imm_E,        r.e.imm);
                chk("stallcnt", ifc.StallCnt,     r.cnt);
                chk("stallcnt_sat", ifs.StallCnt, r.cnt_s);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, ifc.Valid_E,      0);
        chk({tag, "_ctrl"},  ifc.Ctrl_E,       0);
        chk({tag, "_regwr"}, ifc.RegWriteEN_E, 0);
        chk({tag, "_dst"},   ifc.RegDstAddr_E, 0);
        chk({tag, "_rs"},    ifc.RsAddr_E,     0);
        chk({tag, "_rt"},    ifc.RtAddr_E,     0);
        chk({tag, "_pc4"},   ifc.PC4_E,        0);
        chk({tag, "_rsd"},   ifc.RsData_E,     0);
        chk({tag, "_rtd"},   ifc.RtData_E,     0);
        chk({tag, "_imm"},   ifc.Imm_E,        0);
        chk({tag, "_cnt"},   ifc.StallCnt,     0);
        chk({tag, "_cnt_s"}, ifs.StallCnt,     0);
        chk({tag, "_stall"}, ifc.Stall_D,      0);
    endtask

    initial begin
        ifc.Flush    = 1'b0;
        ifc.Valid_D  = 1'b0;
        ifc.RsAddr_D = '0;
        ifc.RtAddr_D = '0;
        ifc.RdAddr_D = '0;
        ifc.Ctrl_D   = '0;
        ifc.PC4_D    = '0;
        ifc.RsData_D = '0;
        ifc.RtData_D = '0;
        ifc.Imm_D    = '0;
        model_reset();
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        #2;
        rst_n = 1'b1;

        // add $3,$1,$2
        drive(1'b0, 1'b1, 5'd1, 5'd2, 5'd3, C_ADD, 32'h104, 32'h11, 32'h22, 32'h0);
        settle();
        chk("add_rs", ifc.RsAddr_E, 1);
        chk("add_rt", ifc.RtAddr_E, 2);
        chk("add_dst", ifc.RegDstAddr_E, 3);
        chk("add_valid", ifc.Valid_E, 1);

        // lw $5,0($1) then dependent add $6,$5,$2: one stall, then capture
        drive(1'b0, 1'b1, 5'd1, 5'd5, 5'd0, C_LW, 32'h108, 32'h11, 32'h55, 32'h0);
        drive(1'b0, 1'b1, 5'd5, 5'd2, 5'd6, C_ADD, 32'h10C, 32'h66, 32'h22, 32'h0);
        #2;
        chk("lu_stall", ifc.Stall_D, 1);
        settle();
        chk("lu_bubble", ifc.Valid_E, 0);
        chk("lu_cnt", ifc.StallCnt, 1);
        drive(1'b0, 1'b1, 5'd5, 5'd2, 5'd6, C_ADD, 32'h10C, 32'h66, 32'h22, 32'h0);
        #2;
        chk("lu_release", ifc.Stall_D, 0);
        settle();
        chk("lu_capture_dst", ifc.RegDstAddr_E, 6);

        // Flush with load-use present: flush wins, counter unchanged
        drive(1'b0, 1'b1, 5'd1, 5'd5, 5'd0, C_LW, 32'h110, 32'h11, 32'h55, 32'h4);
        drive(1'b1, 1'b1, 5'd5, 5'd2, 5'd6, C_ADD, 32'h114, 32'h66, 32'h22, 32'h0);
        #2;
        chk("flush_stall", ifc.Stall_D, 0);
        settle();
        chk("flush_bubble", ifc.Valid_E, 0);
        chk("flush_cnt", ifc.StallCnt, 1);

        // lw $0 then a reader of $0: no stall
        drive(1'b0, 1'b1, 5'd1, 5'd0, 5'd0, C_LW, 32'h118, 32'h11, 32'h0, 32'h8);
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd7, C_ADD, 32'h11C, 32'h0, 32'h0, 32'h0);
        #2;
        chk("zero_stall", ifc.Stall_D, 0);
        settle();

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) != 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  11'($urandom), $urandom, $urandom, $urandom, $urandom);
        end
        settle();

        // Reset asserted mid-stall: immediate clear, no residual bubble or stall
        drive(1'b0, 1'b1, 5'd1, 5'd5, 5'd0, C_LW, 32'h200, 32'h11, 32'h55, 32'h0);
        settle();
        ifc.Flush    = 1'b0;
        ifc.Valid_D  = 1'b1;
        ifc.RsAddr_D = 5'd5;
        ifc.RtAddr_D = 5'd2;
        ifc.RdAddr_D = 5'd6;
        ifc.Ctrl_D   = C_ADD;
        #1;
        chk("prereset_stall", ifc.Stall_D, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        chk("inreset_valid", ifc.Valid_E, 0);
        chk("inreset_stall", ifc.Stall_D, 0);
        ifc.Valid_D = 1'b0;
        rst_n = 1'b1;

        // Repeated load-use stalls drive the narrow counter into saturation
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 5'd1, 5'd5, 5'd0, C_LW, 32'h300, 32'h11, 32'h55, 32'h0);
            drive(1'b0, 1'b1, 5'd5, 5'd2, 5'd6, C_ADD, 32'h304, 32'h66, 32'h22, 32'h0);
            drive(1'b0, 1'b1, 5'd5, 5'd2, 5'd6, C_ADD, 32'h304, 32'h66, 32'h22, 32'h0);
        end
        settle();
        chk("sat_cnt16", ifc.StallCnt, 10);
        chk("sat_cnt_narrow", ifs.StallCnt, MAX_SAT);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) settle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
